// File: rtl/minitb_ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the miniTB master BFM and the slave memory.
// Clock and reset stay outside the bundle as plain ports.
interface minitb_ahb_slave_mem_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
);
    logic [1:0]           htrans;
    logic [addrWidth-1:0] haddr;
    logic                 hwrite;
    logic [dataWidth-1:0] hwdata;
    logic                 hready;
    logic [dataWidth-1:0] hrdata;

    modport master (
        output htrans, haddr, hwrite, hwdata,
        input  hready, hrdata
    );

    modport slave (
        input  htrans, haddr, hwrite, hwdata,
        output hready, hrdata
    );
endinterface

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-Lite slave memory: single-transfer decode, fixed wait states per data
// phase, word-addressed register array with write-to-read forwarding.
//
// state | meaning
// IDLE  | no data phase outstanding; hready held high
// DATA  | data phase in progress; cnt_q counts the remaining wait cycles
module minitb_ahb_slave_mem #(
    parameter int addrWidth  = 8,
    parameter int dataWidth  = 32,
    parameter int waitStates = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    minitb_ahb_slave_mem_if.slave bus
);
    localparam int         Depth    = 2 ** addrWidth;
    localparam logic [3:0] WaitInit = 4'(waitStates);

    if (waitStates < 0 || waitStates > 15) begin : g_bad_wait_states
        $error("minitb_ahb_slave_mem: waitStates must be in 0..15");
    end

    typedef enum logic {IDLE, DATA} state_e;

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [addrWidth-1:0] a_addr_q;
    logic                 a_write_q;
    logic                 hready_q;
    logic [dataWidth-1:0] hrdata_q;
    logic [dataWidth-1:0] hrdata_d;
    logic [dataWidth-1:0] mem_q [Depth];

    logic sample;
    logic complete;
    logic wr_commit;
    logic unused_htrans0;

    assign sample         = hready_q && bus.htrans[1];
    assign complete       = (state_q == DATA) && hready_q;
    assign wr_commit      = complete && a_write_q;
    assign unused_htrans0 = bus.htrans[0];

    // Read data is captured on the edge that opens the final data-phase cycle.
    // With no wait states that is the sample edge itself, which may coincide
    // with a write commit to the same word, so forward the write data.
    always_comb begin
        hrdata_d = hrdata_q;
        if (sample && (waitStates == 0) && !bus.hwrite) begin
            if (wr_commit && (a_addr_q == bus.haddr)) begin
                hrdata_d = bus.hwdata;
            end else begin
                hrdata_d = mem_q[bus.haddr];
            end
        end else if ((state_q == DATA) && (cnt_q == 4'd1) && !a_write_q) begin
            hrdata_d = mem_q[a_addr_q];
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            a_addr_q  <= '0;
            a_write_q <= 1'b0;
            hready_q  <= 1'b1;
            hrdata_q  <= '0;
        end else begin
            hrdata_q <= hrdata_d;
            if (sample) begin
                state_q   <= DATA;
                cnt_q     <= WaitInit;
                hready_q  <= (waitStates == 0);
                a_addr_q  <= bus.haddr;
                a_write_q <= bus.hwrite;
            end else if ((state_q == DATA) && (cnt_q != 4'd0)) begin
                cnt_q    <= cnt_q - 4'd1;
                hready_q <= (cnt_q == 4'd1);
            end else if (complete) begin
                state_q  <= IDLE;
                hready_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_commit) begin
            mem_q[a_addr_q] <= bus.hwdata;
        end
    end

    assign bus.hready = hready_q;
    assign bus.hrdata = hrdata_q;
endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Bench for minitb_ahb_slave_mem: three instances (0, 2 and 3 wait states)
// driven by a pipelined master and checked against an array memory model.
module tb_minitb_ahb_slave_mem;
    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    logic              hclk;
    logic [2:0]        hreset_a;
    logic [1:0]        htrans_a [3];
    logic [7:0]        haddr_a  [3];
    logic              hwrite_a [3];
    logic [31:0]       hwdata_a [3];
    logic [2:0]        hready_a;
    logic [2:0][31:0]  hrdata_a;

    logic [31:0] ref_mem [3][256];
    xfer_t       xq [$];
    int          n_checks;
    int          n_errors;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        minitb_ahb_slave_mem_if #(.addrWidth(8), .dataWidth(32)) bus ();

        assign bus.htrans  = htrans_a[g];
        assign bus.haddr   = haddr_a[g];
        assign bus.hwrite  = hwrite_a[g];
        assign bus.hwdata  = hwdata_a[g];
        assign hready_a[g] = bus.hready;
        assign hrdata_a[g] = bus.hrdata;

        minitb_ahb_slave_mem #(
            .addrWidth (8),
            .dataWidth (32),
            .waitStates(g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) u_dut (
            .hclk  (hclk),
            .hreset(hreset_a[g]),
            .bus   (bus.slave)
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] t, input logic w, input logic [7:0] a, input logic [31:0] dt);
        xfer_t x;
        x.trans = t;
        x.wr    = w;
        x.addr  = a;
        x.data  = dt;
        xq.push_back(x);
    endtask

    // Plays the queued transfers on instance d. While hready is low the
    // address bus carries junk NONSEQ writes, which the slave must ignore.
    task automatic run_xfers(input int d);
        xfer_t pend;
        bit    have_pend;
        int    lows;
        have_pend  = 1'b0;
        pend.trans = 2'b00;
        pend.wr    = 1'b0;
        pend.addr  = 8'h00;
        pend.data  = 32'h0;
        for (int i = 0; i <= xq.size(); i++) begin
            lows = 0;
            forever begin
                hwdata_a[d] = (have_pend && pend.wr) ? pend.data : $urandom;
                if (hready_a[d]) begin
                    if (i < xq.size()) begin
                        htrans_a[d] = xq[i].trans;
                        haddr_a[d]  = xq[i].addr;
                        hwrite_a[d] = xq[i].wr;
                    end else begin
                        htrans_a[d] = 2'b00;
                    end
                    break;
                end
                htrans_a[d] = 2'b10;
                haddr_a[d]  = 8'($urandom);
                hwrite_a[d] = 1'b1;
                lows++;
                if (lows > 20) begin
                    chk("hready_stuck", 32'(hready_a[d]), 32'd1);
                    break;
                end
                @(posedge hclk); #1;
            end
            if (have_pend) begin
                chk("wait_cycles", 32'(lows), 32'(ws_of(d)));
                if (!pend.wr) begin
                    @(negedge hclk);
                    chk("rdata", hrdata_a[d], ref_mem[d][pend.addr]);
                end
            end else begin
                chk("idle_hready", 32'(lows), 32'd0);
            end
            @(posedge hclk); #1;
            if (have_pend && pend.wr) ref_mem[d][pend.addr] = pend.data;
            have_pend = (i < xq.size()) && xq[i].trans[1];
            if (have_pend) pend = xq[i];
        end
        xq.delete();
    endtask

    task automatic reset_abort();
        htrans_a[2] = 2'b10;
        haddr_a[2]  = 8'h20;
        hwrite_a[2] = 1'b1;
        @(posedge hclk); #1;
        htrans_a[2] = 2'b00;
        hwdata_a[2] = 32'h1;
        chk("abort_wait1", 32'(hready_a[2]), 32'd0);
        @(posedge hclk); #1;
        chk("abort_wait2", 32'(hready_a[2]), 32'd0);
        hreset_a[2] = 1'b1;
        @(posedge hclk); #1;
        hreset_a[2] = 1'b0;
        chk("abort_hready", 32'(hready_a[2]), 32'd1);
        chk("abort_hrdata", hrdata_a[2], 32'd0);
        for (int a = 0; a < 256; a++) ref_mem[2][a] = 32'h0;
        add(2'b10, 1'b0, 8'h20, 32'h0);
        add(2'b10, 1'b1, 8'h21, 32'hCAFE_0001);
        add(2'b10, 1'b0, 8'h21, 32'h0);
        run_xfers(2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int d = 0; d < 3; d++) begin
            htrans_a[d] = 2'b00;
            haddr_a[d]  = 8'h00;
            hwrite_a[d] = 1'b0;
            hwdata_a[d] = 32'h0;
            for (int a = 0; a < 256; a++) ref_mem[d][a] = 32'h0;
        end
        hreset_a = 3'b111;
        repeat (2) @(posedge hclk);
        #1;
        hreset_a = 3'b000;
        for (int d = 0; d < 3; d++) begin
            chk("reset_hready", 32'(hready_a[d]), 32'd1);
            chk("reset_hrdata", hrdata_a[d], 32'd0);
            add(2'b10, 1'b0, 8'h10, 32'h0);
            run_xfers(d);
        end

        add(2'b10, 1'b1, 8'h05, 32'hDEAD_BEEF);
        add(2'b10, 1'b0, 8'h05, 32'h0);
        run_xfers(0);

        add(2'b10, 1'b1, 8'h0A, 32'h1234_5678);
        add(2'b10, 1'b0, 8'h0A, 32'h0);
        run_xfers(1);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                add(2'b10, 1'b1, 8'(k), 32'h1000_0000 + 32'(k));
                add((k % 2 == 1) ? 2'b01 : 2'b00, 1'b1, 8'(8'h30 + k), 32'hBAD0_0000 + 32'(k));
            end
            for (int k = 0; k < 4; k++) begin
                add(2'b10, 1'b0, 8'(k), 32'h0);
                add(2'b10, 1'b0, 8'(8'h30 + k), 32'h0);
            end
            run_xfers(d);
        end

        for (int d = 0; d < 3; d++) begin
            add(2'b10, 1'b1, 8'hFF, 32'hA5A5_A5A5);
            add(2'b10, 1'b1, 8'h00, 32'h5A5A_5A5A);
            add(2'b10, 1'b0, 8'hFF, 32'h0);
            add(2'b10, 1'b0, 8'h00, 32'h0);
            run_xfers(d);
        end

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 80; n++) begin
                add(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15)), $urandom);
            end
            run_xfers(d);
        end

        reset_abort();

        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 256; a++) add(2'b10, 1'b0, 8'(a), 32'h0);
            run_xfers(d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
